// File: rtl/cp0_pkg.sv
// Shared CP0 register addresses, Status/Cause field positions and ExcCode values
// used by the interrupt controller and its timer.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam int unsigned ST_IE     = 0;
  localparam int unsigned ST_EXL    = 1;
  localparam int unsigned ST_IM_LSB = 8;
  localparam int unsigned ST_IM7    = 15;

  localparam int unsigned CA_EXC_LSB = 2;
  localparam int unsigned CA_EXC_MSB = 6;
  localparam int unsigned CA_IP_LSB  = 8;
  localparam int unsigned CA_IP7     = 15;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_RI  = 5'd10,
    EXC_OV  = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and sticky IP7 that
// sets when an increment lands on Compare and clears on any Compare write.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_wr,
  input  logic        compare_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ip7
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   count_inc;

  assign tick      = (presc == PW'(COUNT_DIV - 1));
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
      ip7     <= 1'b0;
    end else begin
      if (count_wr) begin
        count <= wr_data;
        presc <= '0;
      end else if (tick) begin
        count <= count_inc;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      // A Compare write beats a simultaneous match.
      if (compare_wr) begin
        compare <= wr_data;
        ip7     <= 1'b0;
      end else if (tick && !count_wr && (count_inc == compare)) begin
        ip7 <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_intc.sv
// CP0 register file and interrupt controller: Status/Cause/EPC, IRQ
// synchronisers, timer and the registered interrupt request to the pipeline.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 5,
  parameter int unsigned COUNT_DIV   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [4:0]         rd_addr,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [4:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               trap_i,
  input  logic [4:0]         trap_code,
  input  logic [31:0]        trap_pc,
  input  logic               eret_i,
  output logic               int_req_o,
  output logic [31:0]        epc_o
);

  logic [NUM_IRQ-1:0] ip;
  logic [NUM_IRQ-1:0] im;
  logic               ie, exl, im7, ip7;
  logic [4:0]         exc_code;
  logic [31:0]        epc, count, compare;
  logic [31:0]        status_rd, cause_rd;
  logic               pend;

  for (genvar k = 0; k < NUM_IRQ; k++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[SYNC_STAGES-2:0], irq_i[k]};
    end
    assign ip[k] = chain[SYNC_STAGES-1];
  end

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_wr   (wr_en && (wr_addr == CP0_COUNT)),
    .compare_wr (wr_en && (wr_addr == CP0_COMPARE)),
    .wr_data    (wr_data),
    .count      (count),
    .compare    (compare),
    .ip7        (ip7)
  );

  // Trap and eret own Status/Cause/EPC in their cycle; an mtc0 there is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie       <= 1'b0;
      exl      <= 1'b0;
      im       <= '0;
      im7      <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
    end else if (trap_i) begin
      exl      <= 1'b1;
      exc_code <= trap_code;
      epc      <= trap_pc;
    end else if (eret_i) begin
      exl <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        CP0_STATUS: begin
          ie  <= wr_data[ST_IE];
          exl <= wr_data[ST_EXL];
          im  <= wr_data[ST_IM_LSB +: NUM_IRQ];
          im7 <= wr_data[ST_IM7];
        end
        CP0_CAUSE: exc_code <= wr_data[CA_EXC_MSB:CA_EXC_LSB];
        CP0_EPC:   epc      <= wr_data;
        default: ;
      endcase
    end
  end

  assign pend = (|({ip7, ip} & {im7, im})) & ie & ~exl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_req_o <= 1'b0;
    else        int_req_o <= pend;
  end

  always_comb begin
    status_rd = '0;
    status_rd[ST_IE] = ie;
    status_rd[ST_EXL] = exl;
    status_rd[ST_IM_LSB +: NUM_IRQ] = im;
    status_rd[ST_IM7] = im7;
    cause_rd = '0;
    cause_rd[CA_EXC_MSB:CA_EXC_LSB] = exc_code;
    cause_rd[CA_IP_LSB +: NUM_IRQ] = ip;
    cause_rd[CA_IP7] = ip7;
  end

  always_comb begin
    case (rd_addr)
      CP0_COUNT:   rd_data = count;
      CP0_COMPARE: rd_data = compare;
      CP0_STATUS:  rd_data = status_rd;
      CP0_CAUSE:   rd_data = cause_rd;
      CP0_EPC:     rd_data = epc;
      default:     rd_data = '0;
    endcase
  end

  assign epc_o = epc;

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc with default parameters
// (NUM_IRQ=5, COUNT_DIV=1, SYNC_STAGES=2).
module tb_cp0_intc;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  irq_i = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        trap_i = 1'b0;
  logic [4:0]  trap_code = '0;
  logic [31:0] trap_pc = '0;
  logic        eret_i = 1'b0;
  logic        int_req_o;
  logic [31:0] epc_o;

  int vectors = 0;
  int miscompares = 0;

  cp0_intc #(.NUM_IRQ(5), .COUNT_DIV(1), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_i     (irq_i),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .trap_i    (trap_i),
    .trap_code (trap_code),
    .trap_pc   (trap_pc),
    .eret_i    (eret_i),
    .int_req_o (int_req_o),
    .epc_o     (epc_o)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, want %08h", nm, act, exp);
    end
  endtask

  task automatic rd_check(input string nm, input logic [4:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(nm, rd_data, exp);
  endtask

  task automatic sb_drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_check(e.name, e.raddr, e.exp);
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    irq_i = '0; wr_en = 1'b0; trap_i = 1'b0; eret_i = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  vec_t tbl[8];
  int   cnt;

  initial begin
    tbl[0] = '{"status_wr_all", 1'b1, CP0_STATUS,  32'hFFFF_FFFF, CP0_STATUS,  32'h0000_9F03};
    tbl[1] = '{"compare_rw",    1'b1, CP0_COMPARE, 32'hDEAD_BEEF, CP0_COMPARE, 32'hDEAD_BEEF};
    tbl[2] = '{"epc_rw",        1'b1, CP0_EPC,     32'h1234_5678, CP0_EPC,     32'h1234_5678};
    tbl[3] = '{"cause_wr_all",  1'b1, CP0_CAUSE,   32'hFFFF_FFFF, CP0_CAUSE,   32'h0000_007C};
    tbl[4] = '{"unmapped_rd0",  1'b0, 5'd0,        32'h0,         5'd0,        32'h0};
    tbl[5] = '{"unmapped_wr",   1'b1, 5'd10,       32'hFFFF_FFFF, 5'd31,       32'h0};
    tbl[6] = '{"status_clr",    1'b1, CP0_STATUS,  32'h0,         CP0_STATUS,  32'h0};
    tbl[7] = '{"epc_clr",       1'b1, CP0_EPC,     32'h0,         CP0_EPC,     32'h0};

    // Reset state
    step();
    step();
    rd_check("rst_count",   CP0_COUNT,   32'h0);
    rd_check("rst_compare", CP0_COMPARE, 32'h0);
    rd_check("rst_status",  CP0_STATUS,  32'h0);
    rd_check("rst_cause",   CP0_CAUSE,   32'h0);
    rd_check("rst_epc",     CP0_EPC,     32'h0);
    check("rst_int_req", {31'd0, int_req_o}, 32'h0);
    check("rst_epc_o", epc_o, 32'h0);
    rst_n = 1'b1;

    // Register read/write table
    do_reset();
    foreach (tbl[i]) begin
      wr_en   = tbl[i].wr;
      wr_addr = tbl[i].waddr;
      wr_data = tbl[i].wdata;
      sb.push_back('{tbl[i].name, tbl[i].raddr, tbl[i].exp});
      step();
      wr_en = 1'b0;
      sb_drain();
    end

    // IRQ -> request -> trap -> eret
    do_reset();
    mtc0(CP0_STATUS, 32'h0000_0101);
    irq_i[0] = 1'b1;
    step(); check("irq_lat1", {31'd0, int_req_o}, 32'h0);
    step(); check("irq_lat2", {31'd0, int_req_o}, 32'h0);
    step(); check("irq_lat3", {31'd0, int_req_o}, 32'h1);
    rd_check("irq_cause_ip0", CP0_CAUSE, 32'h0000_0100);
    trap_i = 1'b1; trap_code = EXC_INT; trap_pc = 32'h0000_0040;
    step();
    trap_i = 1'b0;
    rd_check("trap_epc", CP0_EPC, 32'h0000_0040);
    rd_check("trap_status", CP0_STATUS, 32'h0000_0103);
    check("trap_epc_o", epc_o, 32'h0000_0040);
    step(); check("trap_int_req_off", {31'd0, int_req_o}, 32'h0);
    eret_i = 1'b1;
    step();
    eret_i = 1'b0;
    rd_check("eret_status", CP0_STATUS, 32'h0000_0101);
    check("eret_int_req_n", {31'd0, int_req_o}, 32'h0);
    step(); check("eret_int_req_n1", {31'd0, int_req_o}, 32'h1);

    // Timer match and clear
    do_reset();
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'd0);
    cnt = 0;
    mtc0(CP0_STATUS, 32'h0000_8001);
    cnt++;
    while (cnt < 8) begin
      cnt++;
      sb.push_back('{$sformatf("tmr_count_%0d", cnt), CP0_COUNT, 32'(cnt)});
      sb.push_back('{$sformatf("tmr_cause_%0d", cnt), CP0_CAUSE,
                     (cnt >= 5) ? 32'h0000_8000 : 32'h0});
      step();
      sb_drain();
      check($sformatf("tmr_int_req_%0d", cnt), {31'd0, int_req_o}, (cnt >= 6) ? 32'h1 : 32'h0);
    end
    mtc0(CP0_COMPARE, 32'd20);
    rd_check("tmr_ip7_clr", CP0_CAUSE, 32'h0);
    step(); check("tmr_int_req_clr", {31'd0, int_req_o}, 32'h0);

    // Count wrap
    do_reset();
    mtc0(CP0_COMPARE, 32'h0);
    mtc0(CP0_COUNT, 32'hFFFF_FFFF);
    rd_check("wrap_count_pre", CP0_COUNT, 32'hFFFF_FFFF);
    rd_check("wrap_cause_pre", CP0_CAUSE, 32'h0);
    step();
    rd_check("wrap_count", CP0_COUNT, 32'h0);
    rd_check("wrap_cause", CP0_CAUSE, 32'h0000_8000);

    // Simultaneous events
    do_reset();
    trap_i = 1'b1; trap_code = EXC_SYS; trap_pc = 32'h0000_0080;
    wr_en = 1'b1; wr_addr = CP0_EPC; wr_data = 32'h0000_1234;
    step();
    trap_i = 1'b0; wr_en = 1'b0;
    rd_check("sim_trap_epc", CP0_EPC, 32'h0000_0080);
    rd_check("sim_trap_cause", CP0_CAUSE, 32'h0000_0020);
    check("sim_trap_epc_o", epc_o, 32'h0000_0080);
    do_reset();
    trap_i = 1'b1; eret_i = 1'b1; trap_code = EXC_OV; trap_pc = 32'h0000_0100;
    step();
    trap_i = 1'b0;
    rd_check("sim_trap_eret_status", CP0_STATUS, 32'h0000_0002);
    rd_check("sim_trap_eret_cause", CP0_CAUSE, 32'h0000_0030);
    wr_en = 1'b1; wr_addr = CP0_STATUS; wr_data = 32'h0000_0101;
    step();
    eret_i = 1'b0; wr_en = 1'b0;
    rd_check("sim_eret_mtc0_status", CP0_STATUS, 32'h0);

    // Masking
    do_reset();
    irq_i = 5'b01000;
    mtc0(CP0_STATUS, 32'h0000_0001);
    repeat (4) step();
    check("mask_im3_off", {31'd0, int_req_o}, 32'h0);
    rd_check("mask_cause_ip3", CP0_CAUSE, 32'h0000_0800);
    mtc0(CP0_STATUS, 32'h0000_0800);
    repeat (3) step();
    check("mask_ie_off", {31'd0, int_req_o}, 32'h0);
    mtc0(CP0_STATUS, 32'h0000_0801);
    step();
    check("mask_enabled", {31'd0, int_req_o}, 32'h1);

    // Async reset between edges
    mtc0(CP0_EPC, 32'h0000_0055);
    check("arst_pre_int_req", {31'd0, int_req_o}, 32'h1);
    check("arst_pre_epc_o", epc_o, 32'h0000_0055);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_int_req", {31'd0, int_req_o}, 32'h0);
    check("arst_epc_o", epc_o, 32'h0);
    rd_check("arst_count",   CP0_COUNT,   32'h0);
    rd_check("arst_compare", CP0_COMPARE, 32'h0);
    rd_check("arst_status",  CP0_STATUS,  32'h0);
    rd_check("arst_cause",   CP0_CAUSE,   32'h0);
    rd_check("arst_epc",     CP0_EPC,     32'h0);
    irq_i = '0;
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cp0_intc.md
# cp0_intc

Parametrised CP0 register file and interrupt controller for the PentiumX MIPS core. It sits beside the ID/EX stage. It holds Count, Compare, Status, Cause and EPC. It synchronises external interrupt lines, runs the Count/Compare timer and raises a single interrupt request to the pipeline. It records trap state on exception entry and restores it on `eret`.

## Interface
- `NUM_IRQ`, 5: external interrupt lines, 1..7. Line k maps to Cause.IP[k], bit 8+k.
- `COUNT_DIV`, 1: Count increments once every `COUNT_DIV` clocks, 1..16.
- `SYNC_STAGES`, 2: synchroniser flops per IRQ line, 2..3.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `irq_i`  in  NUM_IRQ  asynchronous level-high interrupt lines.
- `rd_addr`  in  5  CP0 read address, `mfc0`.
- `rd_data`  out  32  combinational read data; unmapped addresses read 0.
- `wr_en`  in  1  `mtc0` write strobe.
- `wr_addr`  in  5  CP0 write address.
- `wr_data`  in  32  `mtc0` data.
- `trap_i`  in  1  pipeline is taking an exception or interrupt this cycle.
- `trap_code`  in  5  ExcCode; 0 means interrupt.
- `trap_pc`  in  32  PC to save in EPC.
- `eret_i`  in  1  `eret` retiring this cycle.
- `int_req_o`  out  1  registered: an enabled interrupt is pending.
- `epc_o`  out  32  current EPC, for `eret` target.

## Operation
- Register map:
  - 9 Count, read/write.
  - 11 Compare, read/write.
  - 12 Status: bit0 IE, bit1 EXL, bits [8+NUM_IRQ-1:8] IM, bit15 IM7 (timer).
  - 13 Cause: [6:2] ExcCode, [8+NUM_IRQ-1:8] IP, bit15 IP7 (timer).
  - 14 EPC, read/write.
  - Unimplemented bits read 0 and ignore writes.
- Cause.IP[k], k < NUM_IRQ, is the synchronised level of `irq_i[k]`, updated every cycle. It is read-only.
- Timer:
  - A prescaler counts to `COUNT_DIV`-1, then Count increments and wraps at 2^32.
  - When the Count value after an increment equals Compare, IP7 sets.
  - IP7 is sticky until any write to Compare clears it.
  - A Count write reloads Count and clears the prescaler.
- Pending: `pend = |(IP & IM) & IE & ~EXL`. `int_req_o` is `pend` registered.
- `trap_i`: EPC <= `trap_pc`, ExcCode <= `trap_code`, EXL <= 1.
- `eret_i`: EXL <= 0.
- Same-cycle priority on Status, Cause and EPC: `trap_i` > `eret_i` > `mtc0`. A losing write is discarded. An `mtc0` to Count or Compare still applies.
- A Compare write in the same cycle as a match clears IP7; the write wins.
- Reset:
  - All registers are 0, `int_req_o`=0 and synchronisers are 0.
  - Prescaler is 0 and the first Count increment occurs after `COUNT_DIV` clocks.
  - An assertion mid-operation takes effect immediately. No writes are lost-tracked.

## Timing
- Reads are combinational, with zero latency.
- A write is visible to reads in the cycle after `wr_en`.
- External IRQ edge to `int_req_o` high: `SYNC_STAGES`+1 clocks, given IE=1, EXL=0 and IM set.
- Count==Compare to `int_req_o`: IP7 sets at the increment edge and `int_req_o` rises one clock later.
- `trap_i` at edge N sets EXL at N. `int_req_o` deasserts at N+1.
- `eret_i` at edge N clears EXL at N. A still-pending interrupt reasserts `int_req_o` at N+1.
- `epc_o` follows EPC one cycle after the write.

## Structure
- Package `cp0_pkg`:
  - Register addresses: `CP0_COUNT`, `CP0_COMPARE`, `CP0_STATUS`, `CP0_CAUSE`, `CP0_EPC`.
  - Status bit indices: `ST_IE`, `ST_EXL`, `ST_IM_LSB`.
  - Cause field positions.
  - ExcCode constants: `EXC_INT`=0, `EXC_SYS`=8, `EXC_RI`=10, `EXC_OV`=12.
- Sub-module `cp0_timer`: prescaler, Count and Compare, with IP7 generation.
- Synchronisers are inline generate loops.

## Test plan
- Reset, IRQ, service, return:
  - Assert reset, then read all five registers -> all 0 and `int_req_o`=0.
  - `mtc0` Status=0x0000_0101, then raise `irq_i[0]` -> `int_req_o`=1 exactly 3 clocks later (`SYNC_STAGES`=2).
  - `trap_i`, code 0, pc 0x0000_0040 -> EPC=0x40, Status=0x103, `int_req_o`=0 next cycle.
  - `eret` with the IRQ still high -> `int_req_o` returns 1 one clock later.
- Timer match and clear:
  - Write Compare=5, Count=0, Status=0x8001, with `COUNT_DIV`=1 -> IP7 sets when Count becomes 5.
  - Cause reads 0x0000_8000 and `int_req_o`=1.
  - Write Compare=20 -> IP7=0.
- Count wrap: write Count=0xFFFF_FFFF and Compare=0 -> Count wraps to 0 and IP7 sets on the wrap.
- Simultaneous events:
  - `trap_i` and `mtc0` EPC=0x1234 in the same cycle, with `trap_pc`=0x80 -> EPC=0x80.
  - `trap_i` and `eret_i` together -> EXL=1.
- Masking: IRQ line 3 high with IM3=0 or IE=0 -> `int_req_o` stays 0, and Cause.IP3 still reads 1.
- Async reset mid-count: pull `rst_n` low between clock edges -> all outputs read 0 before the next edge.
